// File: rtl/wave_gen.sv
// wave_gen: prescaled phase accumulator driving four selectable waveform shapes.
// {c,b} selects saw up / saw down / triangle / square; a is the run enable.
// Optional feature: define WAVE_GEN_PEAK_FLAG_EN to add the registered `peak` output.

module wave_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic [WIDTH-1:0] wave,
    output logic             step
`ifdef WAVE_GEN_PEAK_FLAG_EN
    ,
    output logic             peak
`endif
);

    // DIV=1 would give a zero-width prescaler; keep one bit that never leaves 0.
    localparam int unsigned      PreW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PreW-1:0]  PreLast = PreW'(DIV - 1);
    localparam logic [WIDTH-1:0] Max     = '1;

    logic [PreW-1:0]  pre_q, pre_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic             step_q, step_d;
    logic [WIDTH-1:0] tri_base;

    // State register: reset has priority over the run enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= '0;
            step_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

    // Next state: prescaler counts enabled cycles, phase advances on its terminal count.
    always_comb begin
        pre_d   = pre_q;
        phase_d = phase_q;
        step_d  = 1'b0;
        if (a) begin
            if (pre_q == PreLast) begin
                pre_d   = '0;
                phase_d = phase_q + WIDTH'(1);
                step_d  = 1'b1;
            end else begin
                pre_d = pre_q + PreW'(1);
            end
        end
    end

    // Output shaping: combinational from registered phase and the live select.
    always_comb begin
        tri_base = {phase_q[WIDTH-2:0], 1'b0};
        wave     = '0;
        unique case ({c, b})
            2'b00: wave = phase_q;
            2'b01: wave = Max - phase_q;
            2'b10: wave = phase_q[WIDTH-1] ? (Max - tri_base) : tri_base;
            2'b11: wave = phase_q[WIDTH-1] ? Max : '0;
            default: wave = '0;
        endcase
    end

    assign step = step_q;

`ifdef WAVE_GEN_PEAK_FLAG_EN
    logic peak_q;

    // Peak flag tracks phase==MAX using the next phase so it lines up with wave.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= 1'b0;
        end else if (a) begin
            peak_q <= (phase_d == Max);
        end
    end

    assign peak = peak_q;
`endif

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen (WIDTH=8, DIV=4). Stimulus pushes the expected
// registered response of each cycle; the monitor pops and compares after each edge.

module tb_wave_gen;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic             clk;
    logic             rst;
    logic             a;
    logic             b;
    logic             c;
    logic [WIDTH-1:0] wave;
    logic             step;
`ifdef WAVE_GEN_PEAK_FLAG_EN
    logic             peak;
`endif

    wave_gen #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .c    (c),
        .wave (wave),
        .step (step)
`ifdef WAVE_GEN_PEAK_FLAG_EN
        ,
        .peak (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard queues (kept in lockstep)
    logic [WIDTH-1:0] exp_wave_q[$];
    logic             exp_step_q[$];
    string            exp_name_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: count of enabled cycles since reset
    int   m_cnt  = 0;
    logic m_step = 1'b0;

    // Directed override for the next pushed entry
    bit               hand_en   = 1'b0;
    logic [WIDTH-1:0] hand_wave = '0;
    logic             hand_step = 1'b0;
    string            hand_name = "";

    function automatic logic [WIDTH-1:0] ref_wave(input int p, input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'(p);
            2'd1:    return 8'(255 - p);
            2'd2:    return (p < 128) ? 8'(2 * p) : 8'(255 - 2 * (p - 128));
            default: return (p >= 128) ? 8'd255 : 8'd0;
        endcase
    endfunction

    task automatic expect_next(input string nm, input logic [WIDTH-1:0] w, input logic s);
        hand_en   = 1'b1;
        hand_name = nm;
        hand_wave = w;
        hand_step = s;
    endtask

    task automatic tick(input logic r, input logic ia, input logic ic, input logic ib);
        int ph;
        @(negedge clk);
        rst = r;
        a   = ia;
        c   = ic;
        b   = ib;
        if (r) begin
            m_cnt  = 0;
            m_step = 1'b0;
        end else if (ia) begin
            m_cnt  = m_cnt + 1;
            m_step = ((m_cnt % DIV) == 0);
        end else begin
            m_step = 1'b0;
        end
        ph = (m_cnt / DIV) % 256;
        if (hand_en) begin
            exp_wave_q.push_back(hand_wave);
            exp_step_q.push_back(hand_step);
            exp_name_q.push_back(hand_name);
            hand_en = 1'b0;
        end else begin
            exp_wave_q.push_back(ref_wave(ph, {ic, ib}));
            exp_step_q.push_back(m_step);
            exp_name_q.push_back("model");
        end
    endtask

    task automatic run(input int n, input logic ia, input logic ic, input logic ib);
        for (int i = 0; i < n; i++) tick(1'b0, ia, ic, ib);
    endtask

    // Monitor: one entry per edge that has a pending expectation
    logic [WIDTH-1:0] e_wave;
    logic             e_step;
    string            e_name;
    always @(posedge clk) begin
        #1;
        if (exp_wave_q.size() > 0) begin
            e_wave = exp_wave_q.pop_front();
            e_step = exp_step_q.pop_front();
            e_name = exp_name_q.pop_front();
            checks++;
            if (wave !== e_wave) begin
                errors++;
                $display("FAIL %s wave: got %0d expected %0d at %0t", e_name, wave, e_wave,
                         $time);
            end
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL %s step: got %0b expected %0b at %0t", e_name, step, e_step,
                         $time);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        c   = 1'b0;

        // 1: reset then idle, nothing moves
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_next("reset_state", 8'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        run(29, 1'b0, 1'b0, 1'b0);
        expect_next("idle_300ns", 8'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // 2: saw up, step every 4th cycle, wrap 255->0
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0, 1'b0);
        expect_next("first_step", 8'd1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(1015, 1'b1, 1'b0, 1'b0);
        expect_next("saw_255", 8'd255, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0, 1'b0);
        expect_next("saw_wrap", 8'd0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // 3: saw down
        expect_next("sawdn_rst", 8'd255, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        run(11, 1'b1, 1'b0, 1'b1);
        expect_next("sawdn_3steps", 8'd252, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);

        // 4: triangle around the midpoint and the wrap
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        run(507, 1'b1, 1'b1, 1'b0);
        expect_next("tri_127", 8'd254, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        run(3, 1'b1, 1'b1, 1'b0);
        expect_next("tri_128", 8'd255, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        run(507, 1'b1, 1'b1, 1'b0);
        expect_next("tri_255", 8'd1, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        run(3, 1'b1, 1'b1, 1'b0);
        expect_next("tri_wrap", 8'd0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);

        // 5: square, then live switch to saw up at phase 200
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        run(507, 1'b1, 1'b1, 1'b1);
        expect_next("sq_127", 8'd0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        run(3, 1'b1, 1'b1, 1'b1);
        expect_next("sq_128", 8'd255, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        run(287, 1'b1, 1'b1, 1'b1);
        expect_next("sq_200", 8'd255, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        expect_next("switch_200", 8'd200, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // 6: pause preserves prescaler, reset mid-run and reset beats enable
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0, 1'b0);
        expect_next("resume_nostep", 8'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_next("resume_step", 8'd1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(5, 1'b1, 1'b0, 1'b0);
        expect_next("rst_wins", 8'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0, 1'b0);
        expect_next("post_rst_step", 8'd1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Let the monitor drain the last entry
        @(posedge clk);
        #3;
        checks++;
        if (exp_wave_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_wave_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
